micromips_mc_control_v2: RTL and testbench
==========================================

// Module: micromips_mc_control_v2
// PURPOSE
// Second-generation MicroMIPS multicycle control FSM. Drives datapath selects and write enables from the IR opcode/funct.
// Adds over the first generation: variable-latency memory handshake with timeout, conditional branch resolution
// from ALU flags, an illegal-instruction/timeout fault state, and optional stall-on-muldiv.
// Sits between the IR/ALU flags and the datapath muxes, register file, PC and memory interface.
// PARAMETERS
// MEM_TIMEOUT   15   max cycles a memory access may wait for mem_ready before fault (1..255)
// ALUFUNC_W     4    width of alu_func
// PORTS
// clk          in   1   clock, all state on rising edge
// reset        in   1   synchronous, active-high
// opcode       in   6   IR[31:26], stable from DECODE onward
// funct        in   6   IR[5:0]
// alu_zero     in   1   ALU result == 0 (valid in BRANCH)
// alu_neg      in   1   ALU result sign bit (valid in BRANCH)
// mem_ready    in   1   memory access complete this cycle
// md_done      in   1   mult/div unit finished (used only with MULDIV_EN)
// mem_read, mem_write, inst_data, ir_write, reg_write, pc_write  out 1  enables; inst_data 0=PC addr, 1=ALUout addr
// reg_dst      out  2   0=rt 1=rd 2=r31
// reg_in_src   out  2   0=mem data 1=ALUout 2=PC
// alu_src_x    out  1   0=PC 1=rs
// alu_src_y    out  2   0=const 4 1=rt 2=sext imm 3=sext imm<<2
// alu_func     out  ALUFUNC_W  0 add 1 sub 2 and 3 or 4 xor 5 nor 6 slt 7 lui(Y<<16)
// pc_src       out  2   0=jump target 1=rs 2=ALUout (branch target) 3=ALU result (PC+4)
// md_start     out  1   one-cycle start pulse to mult/div unit
// fault        out  1   sticky; illegal instruction or memory timeout
// state_o      out  4   current state encoding, debug
// BEHAVIOUR
// - Outputs are Moore-decoded from state (+opcode/funct); unlisted outputs are 0 in every state.
// - reset=1 at an edge -> state RST (all outputs 0, wait counter 0, fault 0) regardless of current state; next FETCH.
// - FETCH: mem_read=1, inst_data=0, alu_src_x=0, alu_src_y=0, alu_func=0, pc_src=3. ir_write=pc_write=1 only in the
//   cycle mem_ready=1, then -> DECODE. Wait counter increments each non-ready cycle; reaching MEM_TIMEOUT -> FAULT.
// - DECODE (1 cycle): alu_src_x=0, alu_src_y=3, alu_func=0 (branch target into ALUout). Dispatch:
//   lw 100011/sw 101011 -> ADDR; beq 000100/bne 000101/bltz 000001 -> BRANCH; j 000010/jal 000011 -> JUMP;
//   R-type (000000): jr funct 001000 -> JUMP; add/addu/sub/and/or/xor/nor/slt -> EXEC; mult/div -> MULDIV (macro);
//   addi 001000/slti 001010/andi 001100/ori 001101/xori 001110/lui 001111 -> EXEC; anything else -> FAULT.
// - ADDR: alu_src_x=1, alu_src_y=2, alu_func=0 -> MEM_RD (lw) or MEM_WR (sw).
// - MEM_RD / MEM_WR: inst_data=1, mem_read / mem_write held until mem_ready; same timeout rule as FETCH.
//   MEM_RD -> WB_MEM; MEM_WR -> FETCH. WB_MEM: reg_write=1, reg_dst=0, reg_in_src=0 -> FETCH.
// - EXEC: alu_src_x=1, alu_src_y = 1 (R-type) else 2; alu_func from funct (100000/100001 add, 100010 sub, 100100 and,
//   100101 or, 100110 xor, 100111 nor, 101010 slt) or opcode (addi add, slti slt, andi and, ori or, xori xor, lui 7).
//   -> WB_ALU: reg_write=1, reg_dst=1 (R-type) else 0, reg_in_src=1 -> FETCH.
// - BRANCH: alu_src_x=1, alu_src_y=1 (bltz: rt ignored, compare rs), alu_func=1, pc_src=2;
//   pc_write = beq&alu_zero | bne&!alu_zero | bltz&alu_neg. -> FETCH.
// - JUMP: pc_write=1; pc_src=1 for jr else 0; jal also reg_write=1, reg_dst=2, reg_in_src=2 (PC already +4). -> FETCH.
// - FAULT: all enables 0, fault=1, stays until reset.
// - Wait counter clears on every state change; is 8 bits, never wraps (saturates at MEM_TIMEOUT).
// - mem_ready while not in a memory state is ignored. CPI: R/I 4, lw 5, sw 4, branch/jump 3 (zero wait states).
// CONFIGURATION
// MULDIV_EN defined: funct 011000 mult/011010 div -> MULDIV: md_start=1 on entry cycle only, then wait md_done=1
//   (no timeout) -> FETCH. md_done arriving in the entry cycle is honoured.
// MULDIV_EN undefined: MULDIV state absent, md_start tied 0, md_done ignored, mult/div decode as illegal -> FAULT.
// TESTING
// 1. reset, opcode=000000 funct=100000, mem_ready=1 -> RST,FETCH,DECODE,EXEC,WB_ALU; reg_write=1 reg_dst=1 in cycle 5.
// 2. lw with mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, WB_MEM once, total 8 cycles.
// 3. beq alu_zero=1 -> pc_write=1 pc_src=2; alu_zero=0 -> pc_write=0; bne, bltz alu_neg=1/0 mirrored.
// 4. mem_ready stuck 0 in FETCH, MEM_TIMEOUT=15 -> FAULT after 15 cycles, fault=1 until reset, then RST.
// 5. opcode 111111 -> FAULT from DECODE; reset asserted mid-MEM_WR -> mem_write 0 next cycle, state RST.
// 6. MULDIV_EN: mult, md_done after 5 cycles -> md_start 1 cycle, FETCH after md_done; without macro -> FAULT.

Source files
------------

// File: rtl/micromips_mc_control_v2.sv
// MicroMIPS multicycle control FSM (gen 2): memory handshake with timeout, branch resolution, sticky fault.
// Build macro MULDIV_EN adds the MULDIV stall state for mult/div; without it those decode as illegal.
module micromips_mc_control_v2 #(
   parameter int MEM_TIMEOUT = 15,
   parameter int ALUFUNC_W   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [5:0]           i_opcode,
   input  logic [5:0]           i_funct,
   input  logic                 i_alu_zero,
   input  logic                 i_alu_neg,
   input  logic                 i_mem_ready,
   input  logic                 i_md_done,
   output logic                 o_mem_read,
   output logic                 o_mem_write,
   output logic                 o_inst_data,
   output logic                 o_ir_write,
   output logic                 o_reg_write,
   output logic                 o_pc_write,
   output logic [1:0]           o_reg_dst,
   output logic [1:0]           o_reg_in_src,
   output logic                 o_alu_src_x,
   output logic [1:0]           o_alu_src_y,
   output logic [ALUFUNC_W-1:0] o_alu_func,
   output logic [1:0]           o_pc_src,
   output logic                 o_md_start,
   output logic                 o_fault,
   output logic [3:0]           o_state
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_ADDR   = 4'd3,
      S_MEM_RD = 4'd4,  S_MEM_WR = 4'd5,  S_WB_MEM = 4'd6,  S_EXEC   = 4'd7,
      S_WB_ALU = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10,
`ifdef MULDIV_EN
      S_MULDIV = 4'd11,
`endif
      S_FAULT  = 4'd12
   } state_t;

   localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_inc;
   logic       w_timeout;
   logic       w_rtype;
   logic [3:0] w_r_alu;
   logic [3:0] w_i_alu;
   logic [2:0] w_alu_func;
   logic       w_unused_md_done;

   // {legal, alu_func} for R-type ALU functs
   function automatic logic [3:0] f_r_alu(input logic [5:0] funct);
      case (funct)
         6'b100000, 6'b100001: f_r_alu = {1'b1, 3'd0};
         6'b100010:            f_r_alu = {1'b1, 3'd1};
         6'b100100:            f_r_alu = {1'b1, 3'd2};
         6'b100101:            f_r_alu = {1'b1, 3'd3};
         6'b100110:            f_r_alu = {1'b1, 3'd4};
         6'b100111:            f_r_alu = {1'b1, 3'd5};
         6'b101010:            f_r_alu = {1'b1, 3'd6};
         default:              f_r_alu = {1'b0, 3'd0};
      endcase
   endfunction

   // {legal, alu_func} for immediate ALU opcodes
   function automatic logic [3:0] f_i_alu(input logic [5:0] opcode);
      case (opcode)
         6'b001000: f_i_alu = {1'b1, 3'd0};
         6'b001010: f_i_alu = {1'b1, 3'd6};
         6'b001100: f_i_alu = {1'b1, 3'd2};
         6'b001101: f_i_alu = {1'b1, 3'd3};
         6'b001110: f_i_alu = {1'b1, 3'd4};
         6'b001111: f_i_alu = {1'b1, 3'd7};
         default:   f_i_alu = {1'b0, 3'd0};
      endcase
   endfunction

   assign w_rtype    = (i_opcode == 6'b000000);
   assign w_r_alu    = f_r_alu(i_funct);
   assign w_i_alu    = f_i_alu(i_opcode);
   assign w_alu_func = w_rtype ? w_r_alu[2:0] : w_i_alu[2:0];
   // Saturating so the counter never wraps back below the timeout threshold
   assign w_wait_inc = (r_wait_cnt >= LP_TIMEOUT) ? LP_TIMEOUT : (r_wait_cnt + 8'd1);
   assign w_timeout  = (w_wait_inc >= LP_TIMEOUT);
   assign w_unused_md_done = i_md_done;
   assign o_state    = r_state;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_RST;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= (w_next != r_state) ? 8'd0 : w_wait_inc;
      end
   end

   always_comb begin
      w_next       = r_state;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_inst_data  = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_pc_write   = 1'b0;
      o_reg_dst    = 2'd0;
      o_reg_in_src = 2'd0;
      o_alu_src_x  = 1'b0;
      o_alu_src_y  = 2'd0;
      o_alu_func   = ALUFUNC_W'(3'd0);
      o_pc_src     = 2'd0;
      o_md_start   = 1'b0;
      o_fault      = 1'b0;
      case (r_state)
         S_RST: w_next = S_FETCH;
         S_FETCH: begin
            o_mem_read = 1'b1;
            o_pc_src   = 2'd3;
            if (i_mem_ready) begin
               o_ir_write = 1'b1;
               o_pc_write = 1'b1;
               w_next     = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            o_alu_src_y = 2'd3;
            case (i_opcode)
               6'b100011, 6'b101011:             w_next = S_ADDR;
               6'b000100, 6'b000101, 6'b000001: w_next = S_BRANCH;
               6'b000010, 6'b000011:             w_next = S_JUMP;
               6'b000000: begin
                  if (i_funct == 6'b001000) begin
                     w_next = S_JUMP;
                  end else if (w_r_alu[3]) begin
                     w_next = S_EXEC;
`ifdef MULDIV_EN
                  end else if ((i_funct == 6'b011000) || (i_funct == 6'b011010)) begin
                     w_next = S_MULDIV;
`endif
                  end else begin
                     w_next = S_FAULT;
                  end
               end
               default: w_next = w_i_alu[3] ? S_EXEC : S_FAULT;
            endcase
         end
         S_ADDR: begin
            o_alu_src_x = 1'b1;
            o_alu_src_y = 2'd2;
            w_next      = (i_opcode == 6'b100011) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD, S_MEM_WR: begin
            o_inst_data = 1'b1;
            o_mem_read  = (r_state == S_MEM_RD);
            o_mem_write = (r_state == S_MEM_WR);
            if (i_mem_ready) begin
               w_next = (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end else begin
               w_next = r_state;
            end
         end
         S_WB_MEM: begin
            o_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_EXEC: begin
            o_alu_src_x = 1'b1;
            o_alu_src_y = w_rtype ? 2'd1 : 2'd2;
            o_alu_func  = ALUFUNC_W'(w_alu_func);
            w_next      = S_WB_ALU;
         end
         S_WB_ALU: begin
            o_reg_write  = 1'b1;
            o_reg_dst    = w_rtype ? 2'd1 : 2'd0;
            o_reg_in_src = 2'd1;
            w_next       = S_FETCH;
         end
         S_BRANCH: begin
            o_alu_src_x = 1'b1;
            o_alu_src_y = 2'd1;
            o_alu_func  = ALUFUNC_W'(3'd1);
            o_pc_src    = 2'd2;
            case (i_opcode)
               6'b000100: o_pc_write = i_alu_zero;
               6'b000101: o_pc_write = ~i_alu_zero;
               6'b000001: o_pc_write = i_alu_neg;
               default:   o_pc_write = 1'b0;
            endcase
            w_next = S_FETCH;
         end
         S_JUMP: begin
            o_pc_write = 1'b1;
            o_pc_src   = w_rtype ? 2'd1 : 2'd0;
            if (i_opcode == 6'b000011) begin
               o_reg_write  = 1'b1;
               o_reg_dst    = 2'd2;
               o_reg_in_src = 2'd2;
            end else begin
               o_reg_write  = 1'b0;
            end
            w_next = S_FETCH;
         end
`ifdef MULDIV_EN
         // Counter is cleared on entry, so zero marks the first MULDIV cycle
         S_MULDIV: begin
            o_md_start = (r_wait_cnt == 8'd0);
            w_next     = i_md_done ? S_FETCH : S_MULDIV;
         end
`endif
         S_FAULT: begin
            o_fault = 1'b1;
            w_next  = S_FAULT;
         end
         default: w_next = S_FAULT;
      endcase
   end

endmodule

// File: tb/tb_micromips_mc_control_v2.sv
// Scoreboard bench for micromips_mc_control_v2: per-cycle stimulus and expected output vectors are queued, then
// replayed and compared cycle by cycle. Define MULDIV_EN to exercise the MULDIV path.
module tb_micromips_mc_control_v2;

   localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_ADDR = 4'd3;
   localparam logic [3:0] ST_MEM_RD = 4'd4, ST_MEM_WR = 4'd5, ST_WB_MEM = 4'd6, ST_EXEC = 4'd7;
   localparam logic [3:0] ST_WB_ALU = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_MULDIV = 4'd11;
   localparam logic [3:0] ST_FAULT = 4'd12;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1, i_alu_zero = 1'b0, i_alu_neg = 1'b0, i_mem_ready = 1'b0, i_md_done = 1'b0;
   logic [5:0] i_opcode = 6'd0, i_funct = 6'd0;
   logic       o_mem_read, o_mem_write, o_inst_data, o_ir_write, o_reg_write, o_pc_write;
   logic [1:0] o_reg_dst, o_reg_in_src, o_alu_src_y, o_pc_src;
   logic       o_alu_src_x, o_md_start, o_fault;
   logic [3:0] o_alu_func, o_state;

   typedef struct packed {
      logic [3:0] st;
      logic       mrd, mwr, idata, irw, rw, pcw;
      logic [1:0] rdst, rsrc;
      logic       ax;
      logic [1:0] ay;
      logic [3:0] af;
      logic [1:0] pcs;
      logic       mds, flt;
   } vec_t;

   typedef struct packed {
      logic       rst;
      logic [5:0] op, fn;
      logic       z, n, rdy, md;
   } stim_t;

   vec_t  sb_q[$];
   stim_t st_q[$];
   int    n_vec = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   micromips_mc_control_v2 #(.MEM_TIMEOUT(TIMEOUT), .ALUFUNC_W(4)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_funct(i_funct),
      .i_alu_zero(i_alu_zero), .i_alu_neg(i_alu_neg), .i_mem_ready(i_mem_ready), .i_md_done(i_md_done),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_inst_data(o_inst_data), .o_ir_write(o_ir_write),
      .o_reg_write(o_reg_write), .o_pc_write(o_pc_write), .o_reg_dst(o_reg_dst), .o_reg_in_src(o_reg_in_src),
      .o_alu_src_x(o_alu_src_x), .o_alu_src_y(o_alu_src_y), .o_alu_func(o_alu_func), .o_pc_src(o_pc_src),
      .o_md_start(o_md_start), .o_fault(o_fault), .o_state(o_state)
   );

   function automatic vec_t dut_vec();
      return {o_state, o_mem_read, o_mem_write, o_inst_data, o_ir_write, o_reg_write, o_pc_write, o_reg_dst,
              o_reg_in_src, o_alu_src_x, o_alu_src_y, o_alu_func, o_pc_src, o_md_start, o_fault};
   endfunction

   // Expected-vector builders, one per state, taken from the state output table
   function automatic vec_t e_st(input logic [3:0] st);
      vec_t v; v = '0; v.st = st; return v;
   endfunction
   function automatic vec_t e_fetch(input logic rdy);
      vec_t v; v = e_st(ST_FETCH); v.mrd = 1'b1; v.pcs = 2'd3; v.irw = rdy; v.pcw = rdy; return v;
   endfunction
   function automatic vec_t e_decode();
      vec_t v; v = e_st(ST_DECODE); v.ay = 2'd3; return v;
   endfunction
   function automatic vec_t e_addr();
      vec_t v; v = e_st(ST_ADDR); v.ax = 1'b1; v.ay = 2'd2; return v;
   endfunction
   function automatic vec_t e_mem(input logic wr);
      vec_t v; v = e_st(wr ? ST_MEM_WR : ST_MEM_RD); v.idata = 1'b1; v.mrd = ~wr; v.mwr = wr; return v;
   endfunction
   function automatic vec_t e_wbmem();
      vec_t v; v = e_st(ST_WB_MEM); v.rw = 1'b1; return v;
   endfunction
   function automatic vec_t e_exec(input logic r, input logic [3:0] af);
      vec_t v; v = e_st(ST_EXEC); v.ax = 1'b1; v.ay = r ? 2'd1 : 2'd2; v.af = af; return v;
   endfunction
   function automatic vec_t e_wbalu(input logic r);
      vec_t v; v = e_st(ST_WB_ALU); v.rw = 1'b1; v.rdst = r ? 2'd1 : 2'd0; v.rsrc = 2'd1; return v;
   endfunction
   function automatic vec_t e_branch(input logic taken);
      vec_t v; v = e_st(ST_BRANCH); v.ax = 1'b1; v.ay = 2'd1; v.af = 4'd1; v.pcs = 2'd2; v.pcw = taken;
      return v;
   endfunction
   function automatic vec_t e_jump(input logic jr, input logic jal);
      vec_t v; v = e_st(ST_JUMP); v.pcw = 1'b1; v.pcs = jr ? 2'd1 : 2'd0;
      if (jal) begin v.rw = 1'b1; v.rdst = 2'd2; v.rsrc = 2'd2; end
      return v;
   endfunction
   function automatic vec_t e_fault();
      vec_t v; v = e_st(ST_FAULT); v.flt = 1'b1; return v;
   endfunction
   function automatic vec_t e_muldiv(input logic start);
      vec_t v; v = e_st(ST_MULDIV); v.mds = start; return v;
   endfunction

   function automatic stim_t mk(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic n, input logic rdy, input logic md);
      stim_t s; s.rst = rst; s.op = op; s.fn = fn; s.z = z; s.n = n; s.rdy = rdy; s.md = md; return s;
   endfunction

   task automatic add(input stim_t s, input vec_t e);
      st_q.push_back(s);
      sb_q.push_back(e);
   endtask

   task automatic apply(input stim_t s);
      i_reset = s.rst; i_opcode = s.op; i_funct = s.fn; i_alu_zero = s.z;
      i_alu_neg = s.n; i_mem_ready = s.rdy; i_md_done = s.md;
      @(negedge clk);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
   endtask

   // Full instruction pass through an ALU op, zero wait states
   task automatic seq_alu(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] af);
      logic r;
      r = (op == 6'b000000);
      add(mk(1'b0, op, fn, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, op, fn, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, op, fn, 1'b0, 1'b0, 1'b1, 1'b0), e_exec(r, af));
      add(mk(1'b0, op, fn, 1'b0, 1'b0, 1'b1, 1'b0), e_wbalu(r));
   endtask

   task automatic seq_branch(input logic [5:0] op, input logic z, input logic n, input logic taken);
      add(mk(1'b0, op, 6'd0, z, n, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, op, 6'd0, z, n, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, op, 6'd0, z, n, 1'b1, 1'b0), e_branch(taken));
   endtask

   task automatic test_reset();
      vec_t exp_v, got_v;
      int k = 0;
      do_reset();
      add(mk(1'b0, 6'b111111, 6'b111111, 1'b1, 1'b1, 1'b1, 1'b1), e_st(ST_RST));
      add(mk(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
      while (st_q.size() > 0) begin
         apply(st_q.pop_front());
         exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
         if (got_v !== exp_v) begin
            n_bad++; $display("FAIL reset[%0d]: got %h, want %h", k, got_v, exp_v);
         end
         k++; @(posedge clk); #1;
      end
   endtask

   task automatic test_alu();
      vec_t exp_v, got_v;
      int k = 0;
      do_reset();
      add(mk(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0), e_st(ST_RST));
      seq_alu(6'b000000, 6'b100000, 4'd0);
      seq_alu(6'b000000, 6'b100001, 4'd0);
      seq_alu(6'b000000, 6'b100010, 4'd1);
      seq_alu(6'b000000, 6'b100100, 4'd2);
      seq_alu(6'b000000, 6'b100111, 4'd5);
      seq_alu(6'b000000, 6'b101010, 4'd6);
      seq_alu(6'b001000, 6'b100111, 4'd0);
      seq_alu(6'b001010, 6'b100000, 4'd6);
      seq_alu(6'b001101, 6'b000000, 4'd3);
      seq_alu(6'b001110, 6'b000000, 4'd4);
      seq_alu(6'b001111, 6'b101010, 4'd7);
      while (st_q.size() > 0) begin
         apply(st_q.pop_front());
         exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
         if (got_v !== exp_v) begin
            n_bad++; $display("FAIL alu[%0d]: got %h, want %h", k, got_v, exp_v);
         end
         k++; @(posedge clk); #1;
      end
   endtask

   task automatic test_mem();
      vec_t exp_v, got_v;
      int k = 0;
      do_reset();
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_st(ST_RST));
      // lw: two fetch waits, stray mem_ready in DECODE/ADDR, three MEM_RD waits
      for (int i = 0; i < 2; i++) add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_addr());
      for (int i = 0; i < 3; i++) add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_mem(1'b0));
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_mem(1'b0));
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_wbmem());
      // sw, zero wait states, back to back
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_addr());
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_mem(1'b1));
      // sw again, reset asserted while MEM_WR waits
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_addr());
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_mem(1'b1));
      add(mk(1'b1, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_mem(1'b1));
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_st(ST_RST));
      add(mk(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
      while (st_q.size() > 0) begin
         apply(st_q.pop_front());
         exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
         if (got_v !== exp_v) begin
            n_bad++; $display("FAIL mem[%0d]: got %h, want %h", k, got_v, exp_v);
         end
         k++; @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_jump();
      vec_t exp_v, got_v;
      int k = 0;
      do_reset();
      add(mk(1'b0, 6'b000100, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0), e_st(ST_RST));
      seq_branch(6'b000100, 1'b1, 1'b0, 1'b1);
      seq_branch(6'b000100, 1'b0, 1'b1, 1'b0);
      seq_branch(6'b000101, 1'b0, 1'b0, 1'b1);
      seq_branch(6'b000101, 1'b1, 1'b1, 1'b0);
      seq_branch(6'b000001, 1'b0, 1'b1, 1'b1);
      seq_branch(6'b000001, 1'b1, 1'b0, 1'b0);
      add(mk(1'b0, 6'b000010, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b000010, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'b000010, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_jump(1'b0, 1'b0));
      add(mk(1'b0, 6'b000011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b000011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'b000011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_jump(1'b0, 1'b1));
      add(mk(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b1, 1'b0), e_jump(1'b1, 1'b0));
      add(mk(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
      while (st_q.size() > 0) begin
         apply(st_q.pop_front());
         exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
         if (got_v !== exp_v) begin
            n_bad++; $display("FAIL branch_jump[%0d]: got %h, want %h", k, got_v, exp_v);
         end
         k++; @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      vec_t exp_v, got_v;
      int k = 0;
      // FETCH stuck: TIMEOUT fetch cycles, then sticky FAULT until reset
      do_reset();
      add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_st(ST_RST));
      for (int i = 0; i < TIMEOUT; i++) add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
      for (int i = 0; i < 3; i++) add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b1), e_fault());
      add(mk(1'b1, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_fault());
      add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_st(ST_RST));
      // Ready on the last allowed cycle is honoured
      for (int i = 0; i < TIMEOUT - 1; i++) add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
      add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_decode());
      add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_exec(1'b1, 4'd0));
      add(mk(1'b0, 6'd0, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0), e_wbalu(1'b1));
      // MEM_RD stuck
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_decode());
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_addr());
      for (int i = 0; i < TIMEOUT; i++) add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0), e_mem(1'b0));
      add(mk(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_fault());
      while (st_q.size() > 0) begin
         apply(st_q.pop_front());
         exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
         if (got_v !== exp_v) begin
            n_bad++; $display("FAIL timeout[%0d]: got %h, want %h", k, got_v, exp_v);
         end
         k++; @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      vec_t exp_v, got_v;
      logic [11:0] ill [4];
      ill[0] = {6'b111111, 6'b000000};
      ill[1] = {6'b000000, 6'b100011};
      ill[2] = {6'b100000, 6'b100000};
      ill[3] = {6'b000000, 6'b000000};
      for (int t = 0; t < 4; t++) begin
         int k = 0;
         do_reset();
         add(mk(1'b0, ill[t][11:6], ill[t][5:0], 1'b0, 1'b0, 1'b1, 1'b0), e_st(ST_RST));
         add(mk(1'b0, ill[t][11:6], ill[t][5:0], 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
         add(mk(1'b0, ill[t][11:6], ill[t][5:0], 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
         add(mk(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0), e_fault());
         add(mk(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0), e_fault());
         while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
            if (got_v !== exp_v) begin
               n_bad++; $display("FAIL illegal%0d[%0d]: got %h, want %h", t, k, got_v, exp_v);
            end
            k++; @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_muldiv();
      vec_t exp_v, got_v;
      int k = 0;
      do_reset();
      add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0), e_st(ST_RST));
      add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
`ifdef MULDIV_EN
      add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b0), e_muldiv(1'b1));
      for (int i = 0; i < 3; i++) add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b0), e_muldiv(1'b0));
      add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b1), e_muldiv(1'b0));
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b1, 1'b0), e_fetch(1'b1));
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b1, 1'b0), e_decode());
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b0, 1'b1), e_muldiv(1'b1));
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b0, 1'b0), e_fetch(1'b0));
`else
      add(mk(1'b0, 6'd0, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b1), e_fault());
      add(mk(1'b1, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b0, 1'b1), e_fault());
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b1, 1'b1), e_st(ST_RST));
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b1, 1'b1), e_fetch(1'b1));
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b1, 1'b1), e_decode());
      add(mk(1'b0, 6'd0, 6'b011010, 1'b0, 1'b0, 1'b1, 1'b1), e_fault());
`endif
      while (st_q.size() > 0) begin
         apply(st_q.pop_front());
         exp_v = sb_q.pop_front(); got_v = dut_vec(); n_vec++;
         if (got_v !== exp_v) begin
            n_bad++; $display("FAIL muldiv[%0d]: got %h, want %h", k, got_v, exp_v);
         end
         k++; @(posedge clk); #1;
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_alu();
      test_mem();
      test_branch_jump();
      test_timeout();
      test_illegal();
      test_muldiv();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
